// File: rtl/ppc_decode_pkg.sv
// Shared decode constants: one-hot format bit positions, vector width and
// the primary opcodes that select each instruction format.
package ppc_decode_pkg;

    localparam int FMT_WIDTH = 26;
    localparam int OPC_W     = 6;
    localparam int XO_W      = 6;

    // Bit positions inside the one-hot format vector
    localparam int I_FMT   = 0;
    localparam int B_FMT   = 1;
    localparam int SC_FMT  = 2;
    localparam int D_FMT   = 3;
    localparam int DS_FMT  = 4;
    localparam int DQ_FMT  = 5;
    localparam int DX_FMT  = 6;
    localparam int X_FMT   = 7;
    localparam int XL_FMT  = 8;
    localparam int XFX_FMT = 9;
    localparam int XFL_FMT = 10;
    localparam int XX1_FMT = 11;
    localparam int XX2_FMT = 12;
    localparam int XX3_FMT = 13;
    localparam int XX4_FMT = 14;
    localparam int XS_FMT  = 15;
    localparam int XO_FMT  = 16;
    localparam int A_FMT   = 17;
    localparam int M_FMT   = 18;
    localparam int MD_FMT  = 19;
    localparam int MDS_FMT = 20;
    localparam int VA_FMT  = 21;
    localparam int VC_FMT  = 22;
    localparam int VX_FMT  = 23;
    localparam int Z22_FMT = 24;
    localparam int Z23_FMT = 25;

    // Primary opcodes with a dedicated format
    localparam logic [OPC_W-1:0] OPC_VEC    = 6'd4;
    localparam logic [OPC_W-1:0] OPC_B      = 6'd16;
    localparam logic [OPC_W-1:0] OPC_SC     = 6'd17;
    localparam logic [OPC_W-1:0] OPC_I      = 6'd18;
    localparam logic [OPC_W-1:0] OPC_XL     = 6'd19;
    localparam logic [OPC_W-1:0] OPC_RLWIMI = 6'd20;
    localparam logic [OPC_W-1:0] OPC_RLWINM = 6'd21;
    localparam logic [OPC_W-1:0] OPC_RLWNM  = 6'd23;
    localparam logic [OPC_W-1:0] OPC_MD     = 6'd30;
    localparam logic [OPC_W-1:0] OPC_X      = 6'd31;
    localparam logic [OPC_W-1:0] OPC_DS_LD  = 6'd58;
    localparam logic [OPC_W-1:0] OPC_FP_S   = 6'd59;
    localparam logic [OPC_W-1:0] OPC_DS_ST  = 6'd62;
    localparam logic [OPC_W-1:0] OPC_FP_D   = 6'd63;

    // Extended-opcode boundaries that split vector and floating-point groups
    localparam logic [XO_W-1:0] VA_XO_LO  = 6'd32;
    localparam logic [XO_W-1:0] VA_XO_HI  = 6'd47;
    localparam logic [XO_W-2:0] A_XO_MIN  = 5'd18;

    // One-hot vector with only the given format bit set
    function automatic logic [FMT_WIDTH-1:0] fmt_onehot(input int idx);
        return FMT_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/format_classifier.sv
// Combinational primary-opcode classifier producing the one-hot format and
// an illegal flag for opcodes no format decoder handles.
module format_classifier
    import ppc_decode_pkg::*;
(
    input  logic [OPC_W-1:0]     opcode,
    input  logic [XO_W-1:0]      ext_op,
    output logic [FMT_WIDTH-1:0] format,
    output logic                 illegal
);

    // Map opcode (and extended field for vector/FP groups) to a format bit
    always_comb begin
        format  = {FMT_WIDTH{1'b0}};
        illegal = 1'b0;
        case (opcode) inside
            OPC_I:  format = fmt_onehot(I_FMT);
            OPC_B:  format = fmt_onehot(B_FMT);
            OPC_SC: format = fmt_onehot(SC_FMT);
            OPC_XL: format = fmt_onehot(XL_FMT);
            OPC_X:  format = fmt_onehot(X_FMT);
            OPC_MD: format = fmt_onehot(MD_FMT);
            OPC_RLWIMI, OPC_RLWINM, OPC_RLWNM:
                format = fmt_onehot(M_FMT);
            OPC_DS_LD, OPC_DS_ST:
                format = fmt_onehot(DS_FMT);
            6'd7, 6'd8, [6'd10:6'd15], [6'd24:6'd29], [6'd32:6'd47]:
                format = fmt_onehot(D_FMT);
            OPC_VEC: begin
                if (ext_op >= VA_XO_LO && ext_op <= VA_XO_HI) begin
                    format = fmt_onehot(VA_FMT);
                end else begin
                    format = fmt_onehot(VX_FMT);
                end
            end
            OPC_FP_S, OPC_FP_D: begin
                // A-form arithmetic lives in the upper half of the 5-bit XO space
                if (ext_op[XO_W-1:1] >= A_XO_MIN) begin
                    format = fmt_onehot(A_FMT);
                end else begin
                    format = fmt_onehot(X_FMT);
                end
            end
            default: begin
                format  = {FMT_WIDTH{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/format_dispatch.sv
// Dispatch stage: classifies fetched instructions, stamps a major ID and
// buffers them in a small FIFO feeding the per-format decoders.
module format_dispatch
    import ppc_decode_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatWidth             = 26,
    parameter int fifoDepth               = 4
) (
    input  logic                               clock_i,
    input  logic                               resetn_i,
    input  logic                               fetchValid_i,
    output logic                               fetchReady_o,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               enable_o,
    output logic [formatWidth-1:0]             instFormat_o,
    output logic                               illegal_o,
    output logic [opcodeSize-1:0]              instructionOpcode_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
);

    localparam int PTR_W = $clog2(fifoDepth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(fifoDepth);

    logic [CNT_W-1:0]                   count_r;
    logic [PTR_W-1:0]                   wr_ptr_r;
    logic [PTR_W-1:0]                   rd_ptr_r;
    logic [instructionCounterWidth-1:0] maj_ctr_r;

    logic [instructionWidth-1:0]        instr_mem_r [fifoDepth];
    logic [addressWidth-1:0]            addr_mem_r  [fifoDepth];
    logic [PidSize-1:0]                 pid_mem_r   [fifoDepth];
    logic [TidSize-1:0]                 tid_mem_r   [fifoDepth];
    logic [formatWidth-1:0]             fmt_mem_r   [fifoDepth];
    logic                               ill_mem_r   [fifoDepth];
    logic [instructionCounterWidth-1:0] maj_mem_r   [fifoDepth];

    logic [FMT_WIDTH-1:0] cls_format_s;
    logic                 cls_illegal_s;
    logic                 not_empty_s;
    logic                 push_s;
    logic                 pop_s;

    // Instruction bit 0 is the MSB, so opcode = [31:26] and bits 26..31 = [5:0]
    format_classifier u_classifier (
        .opcode  (instruction_i[instructionWidth-1 -: OPC_W]),
        .ext_op  (instruction_i[XO_W-1:0]),
        .format  (cls_format_s),
        .illegal (cls_illegal_s)
    );

    // Ready depends only on registered occupancy, so a pop never frees a full slot early
    assign fetchReady_o = (count_r < DEPTH_C);
    assign not_empty_s  = (count_r != {CNT_W{1'b0}});
    assign push_s       = fetchValid_i && fetchReady_o && !flush_i;
    assign pop_s        = not_empty_s && !stall_i && !flush_i;

    // Occupancy, pointers and major-ID counter; flush clears the queue but keeps IDs monotonic
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            count_r   <= {CNT_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            maj_ctr_r <= {instructionCounterWidth{1'b0}};
        end else if (flush_i) begin
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r  <= wr_ptr_r + PTR_W'(1);
                maj_ctr_r <= maj_ctr_r + instructionCounterWidth'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; unread slots are masked at the output so no reset is needed
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= instruction_i;
            addr_mem_r[wr_ptr_r]  <= instructionAddress_i;
            pid_mem_r[wr_ptr_r]   <= instructionPid_i;
            tid_mem_r[wr_ptr_r]   <= instructionTid_i;
            fmt_mem_r[wr_ptr_r]   <= cls_format_s;
            ill_mem_r[wr_ptr_r]   <= cls_illegal_s;
            maj_mem_r[wr_ptr_r]   <= maj_ctr_r;
        end
    end

    // Present the head entry from registers, forced to zero while the FIFO is empty
    always_comb begin
        enable_o = not_empty_s;
        if (not_empty_s) begin
            instFormat_o         = fmt_mem_r[rd_ptr_r];
            illegal_o            = ill_mem_r[rd_ptr_r];
            instruction_o        = instr_mem_r[rd_ptr_r];
            instructionOpcode_o  = instr_mem_r[rd_ptr_r][instructionWidth-1 -: opcodeSize];
            instructionAddress_o = addr_mem_r[rd_ptr_r];
            instructionPid_o     = pid_mem_r[rd_ptr_r];
            instructionTid_o     = tid_mem_r[rd_ptr_r];
            instructionMajId_o   = maj_mem_r[rd_ptr_r];
        end else begin
            instFormat_o         = {formatWidth{1'b0}};
            illegal_o            = 1'b0;
            instruction_o        = {instructionWidth{1'b0}};
            instructionOpcode_o  = {opcodeSize{1'b0}};
            instructionAddress_o = {addressWidth{1'b0}};
            instructionPid_o     = {PidSize{1'b0}};
            instructionTid_o     = {TidSize{1'b0}};
            instructionMajId_o   = {instructionCounterWidth{1'b0}};
        end
    end

endmodule

// File: tb/tb_format_dispatch.sv
// Scoreboard bench for format_dispatch: a driver issues directed and random
// traffic, a negedge monitor models the queue and compares every head.
module tb_format_dispatch;

    logic        clock_i  = 1'b0;
    logic        resetn_i = 1'b1;
    logic        fetchValid_i = 1'b0;
    logic        fetchReady_o;
    logic [31:0] instruction_i = 32'd0;
    logic [63:0] instructionAddress_i = 64'd0;
    logic [19:0] instructionPid_i = 20'd0;
    logic [15:0] instructionTid_i = 16'd0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        enable_o;
    logic [25:0] instFormat_o;
    logic        illegal_o;
    logic [5:0]  instructionOpcode_o;
    logic [31:0] instruction_o;
    logic [63:0] instructionAddress_o;
    logic [19:0] instructionPid_o;
    logic [15:0] instructionTid_o;
    logic [63:0] instructionMajId_o;

    format_dispatch dut (
        .clock_i              (clock_i),
        .resetn_i             (resetn_i),
        .fetchValid_i         (fetchValid_i),
        .fetchReady_o         (fetchReady_o),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .instructionPid_i     (instructionPid_i),
        .instructionTid_i     (instructionTid_i),
        .flush_i              (flush_i),
        .stall_i              (stall_i),
        .enable_o             (enable_o),
        .instFormat_o         (instFormat_o),
        .illegal_o            (illegal_o),
        .instructionOpcode_o  (instructionOpcode_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .instructionPid_o     (instructionPid_o),
        .instructionTid_o     (instructionTid_o),
        .instructionMajId_o   (instructionMajId_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [63:0] maj;
        logic [25:0] fmt;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] maj_model = 64'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic        timeout_r = 1'b0;
    int          op_list [16] = '{4, 16, 17, 18, 19, 31, 30, 20, 21, 23, 58, 62, 59, 63, 1, 7};

    // Reference classification straight from the opcode table
    function automatic void ref_class(input logic [31:0] ins, output logic [25:0] f, output logic ill);
        int op, xo, k;
        op = int'(ins[31:26]);
        xo = int'(ins[5:0]);
        k  = -1;
        if (op == 18) k = 0;
        else if (op == 16) k = 1;
        else if (op == 17) k = 2;
        else if (op == 19) k = 8;
        else if (op == 31) k = 7;
        else if (op == 30) k = 19;
        else if (op == 20 || op == 21 || op == 23) k = 18;
        else if (op == 58 || op == 62) k = 4;
        else if (op == 7 || op == 8 || (op >= 10 && op <= 15) ||
                 (op >= 24 && op <= 29) || (op >= 32 && op <= 47)) k = 3;
        else if (op == 4) k = (xo >= 32 && xo <= 47) ? 21 : 23;
        else if (op == 59 || op == 63) k = ((xo / 2) >= 18) ? 17 : 7;
        if (k < 0) begin
            f = 26'd0;
            ill = 1'b1;
        end else begin
            f = 26'(2 ** k);
            ill = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compare head against model, then apply this cycle's pop/push/flush
    always @(negedge clock_i) begin
        exp_t e;
        logic [25:0] f;
        logic ill;
        check("no_timeout", 64'(timeout_r), 64'd0);
        if (!resetn_i) begin
            exp_q.delete();
            maj_model = 64'd0;
            check("rst_enable", 64'(enable_o), 64'd0);
            check("rst_format", 64'(instFormat_o), 64'd0);
            check("rst_illegal", 64'(illegal_o), 64'd0);
            check("rst_instr", 64'(instruction_o), 64'd0);
            check("rst_majid", instructionMajId_o, 64'd0);
            check("rst_addr", instructionAddress_o, 64'd0);
        end else begin
            check("ready", 64'(fetchReady_o), 64'(exp_q.size() < 4));
            check("enable", 64'(enable_o), 64'(exp_q.size() != 0));
            if (enable_o && exp_q.size() != 0) begin
                e = exp_q[0];
                check("format", 64'(instFormat_o), 64'(e.fmt));
                check("illegal", 64'(illegal_o), 64'(e.ill));
                check("opcode", 64'(instructionOpcode_o), 64'(e.instr[31:26]));
                check("instr", 64'(instruction_o), 64'(e.instr));
                check("addr", instructionAddress_o, e.addr);
                check("pid", 64'(instructionPid_o), 64'(e.pid));
                check("tid", 64'(instructionTid_o), 64'(e.tid));
                check("majid", instructionMajId_o, e.maj);
            end else if (!enable_o) begin
                check("idle_format", 64'(instFormat_o), 64'd0);
                check("idle_illegal", 64'(illegal_o), 64'd0);
                check("idle_instr", 64'(instruction_o), 64'd0);
                check("idle_majid", instructionMajId_o, 64'd0);
                check("idle_pid", 64'({instructionPid_o, instructionTid_o}), 64'd0);
            end
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && !stall_i) void'(exp_q.pop_front());
                if (fetchValid_i && exp_q.size() + (stall_i ? 0 : 0) >= 0 &&
                    fetchValid_i && fetchReady_o) begin
                    ref_class(instruction_i, f, ill);
                    e.instr = instruction_i;
                    e.addr  = instructionAddress_i;
                    e.pid   = instructionPid_i;
                    e.tid   = instructionTid_i;
                    e.maj   = maj_model;
                    e.fmt   = f;
                    e.ill   = ill;
                    exp_q.push_back(e);
                    maj_model = maj_model + 64'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins);
        fetchValid_i         = v;
        instruction_i        = ins;
        instructionAddress_i = {$urandom, $urandom};
        instructionPid_i     = 20'($urandom);
        instructionTid_i     = 16'($urandom);
    endtask

    // Offer one instruction and hold it until accepted (bounded wait)
    task automatic push_wait(input logic [31:0] ins);
        logic acc;
        acc = 1'b0;
        set_in(1'b1, ins);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock_i);
            acc = fetchReady_o && !flush_i;
            step();
        end
        if (!acc) timeout_r = 1'b1;
        fetchValid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        fetchValid_i = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(1, 0) == 1) r[31:26] = 6'(op_list[$urandom_range(15, 0)]);
        return r;
    endfunction

    // Driver: directed scenarios followed by randomized traffic
    initial begin
        #2 resetn_i = 1'b0;
        repeat (3) step();
        resetn_i = 1'b1;
        idle(2);

        // single I-form push after reset
        push_wait(32'h4800_0010);
        idle(2);

        // back-to-back B then X
        push_wait(32'h4000_0020);
        push_wait(32'h7C00_0214);
        idle(2);

        // fill under stall, fifth held, then drain
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) push_wait(rand_instr());
        set_in(1'b1, 32'hE800_0000);
        repeat (3) step();
        stall_i = 1'b0;
        push_wait(32'hE800_0000);
        idle(6);

        // illegal opcode followed by a legal one
        push_wait(32'h0400_0000);
        push_wait(32'h4800_0004);
        idle(3);

        // vector / FP boundaries
        push_wait(32'h1000_001F);
        push_wait(32'h1000_0020);
        push_wait(32'h1000_002F);
        push_wait(32'h1000_0030);
        push_wait(32'hFC00_0024);
        push_wait(32'hFC00_0022);
        idle(3);

        // full FIFO, flush with a simultaneous push, then a fresh push
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) push_wait(rand_instr());
        set_in(1'b1, 32'h4800_0000);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        fetchValid_i = 1'b0;
        stall_i = 1'b0;
        step();
        push_wait(32'h4000_0000);
        idle(3);

        // asynchronous reset mid-stream
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) push_wait(rand_instr());
        resetn_i = 1'b0;
        stall_i = 1'b0;
        repeat (2) step();
        resetn_i = 1'b1;
        step();
        push_wait(32'h4800_0010);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(3, 0) != 0), rand_instr());
            stall_i = 1'($urandom_range(3, 0) == 0);
            flush_i = 1'($urandom_range(39, 0) == 0);
            step();
        end
        flush_i = 1'b0;
        stall_i = 1'b0;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/format_dispatch.md
# format_dispatch

Front-end dispatch stage placed between instruction fetch and the per-format decoders (A, B, D, … format decoders). It accepts fetched instructions with a valid/ready handshake and classifies each one by primary opcode into a 26-bit one-hot format vector. It stamps each instruction with a monotonically increasing major ID, buffers it in a small FIFO, and presents it to the decoders with enable/stall flow control.

## Interface
Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, fixed POWER instruction size
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- opcodeSize, 6, primary opcode width
- formatWidth, 26, one-hot format vector width
- fifoDepth, 4, buffer entries (power of two, ≥2)

Ports:
- clock_i  in  1  clock, all state on rising edge
- resetn_i  in  1  asynchronous, active-low reset
- fetchValid_i  in  1  fetch presents an instruction
- fetchReady_o  out  1  stage can accept this cycle
- instruction_i  in  instructionWidth  raw instruction, bit 0 = MSB
- instructionAddress_i  in  addressWidth  fetch address
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- flush_i  in  1  discard all buffered instructions
- stall_i  in  1  decoders cannot consume this cycle
- enable_o  out  1  head instruction valid to decoders
- instFormat_o  out  formatWidth  one-hot format, see Operation
- illegal_o  out  1  head opcode unrecognised
- instructionOpcode_o  out  opcodeSize  instruction[0:5]
- instruction_o  out  instructionWidth  raw instruction
- instructionAddress_o  out  addressWidth
- instructionPid_o  out  PidSize
- instructionTid_o  out  TidSize
- instructionMajId_o  out  instructionCounterWidth  assigned major ID

## Operation
- Accept when fetchValid_i && fetchReady_o; fetchReady_o = (count < fifoDepth), derived from registered count only.
- On accept: classify, write entry {payload, format, illegal, majId = majCounter}, majCounter += 1, wrapping modulo 2^instructionCounterWidth.
- Format bit k has value 2**k in instFormat_o: I=0, B=1, SC=2, D=3, DS=4, DQ=5, DX=6, X=7, XL=8, XFX=9, XFL=10, XX1=11, XX2=12, XX3=13, XX4=14, XS=15, XO=16, A=17, M=18, MD=19, MDS=20, VA=21, VC=22, VX=23, Z22=24, Z23=25.
- Opcode map: 18→I; 16→B; 17→SC; 19→XL; 31→X; 30→MD; 20,21,23→M; 58,62→DS; 7,8,10–15,24–29,32–47→D; 4→VA if instruction[26:31] in 32..47, else VX; 59,63→A if instruction[26:30] ≥ 18, else X.
- Any other opcode: instFormat_o = 0, illegal_o = 1. The instruction is still dispatched and consumes a major ID.
- Consume: head pops when enable_o && !stall_i. While stall_i is high, all outputs hold stable.
- enable_o = (count != 0). When enable_o = 0, every payload output, instFormat_o and illegal_o read 0.
- Simultaneous push and pop with count < fifoDepth: count unchanged, both pointers advance.
- Full: fetchReady_o = 0 even if a pop occurs in the same cycle.
- flush_i: next edge sets count and pointers to 0. A push in the flush cycle is discarded and does not advance majCounter. majCounter is not reset by flush.
- Reset (asynchronous, resetn_i low): count, pointers and majCounter = 0; enable_o = 0; all data outputs = 0; fetchReady_o = 1 after release. Reset mid-stream drops all entries.

## Timing
- Accept at edge N → visible on outputs after edge N (enable_o high in cycle N+1) when the FIFO was empty. Latency 1 cycle.
- No combinational path from fetch inputs to any output.
- stall_i affects pop only; it never gates accept.
- Throughput: 1 instruction/cycle sustained with stall_i low.

## Structure
- Shared package ppc_decode_pkg holds the format bit indices (I_FMT … Z23_FMT), the one-hot width, and the opcode constants. The format decoders use the same constants.
- Sub-module format_classifier: purely combinational, inputs opcode plus instruction[26:31], outputs {format, illegal}.
- FIFO storage and majCounter live in the top module.

## Test plan
- Reset then single push of 0x48000010 (opcode 18) → cycle after accept: enable_o=1, instFormat_o=0x1, majId=0, illegal_o=0.
- Push opcode 16 then opcode 31 back-to-back with stall_i=0 → outputs in consecutive cycles: formats 0x2 then 0x80, majIds 0 then 1.
- Hold stall_i=1, push 5 instructions → fetchReady_o drops after the 4th accept. The 5th is held by fetch, and head outputs stay constant. Release stall → 4 pops in order, then the 5th is accepted.
- Opcode 1 pushed → illegal_o=1, instFormat_o=0, still popped, and the next instruction gets majId+1.
- Full FIFO plus flush_i with a simultaneous push → next cycle enable_o=0 and fetchReady_o=1. A subsequent push gets majId equal to the previous counter value (no reuse, no skip).
- Assert resetn_i low asynchronously mid-stream → all outputs 0 immediately. After release, the first push gets majId=0.
